// File: rtl/rect_fill_writer.sv
// rtl/rect_fill_writer.sv - rectangle fill initiator for the frame-buffer program port
// Streams one clipped, row-major pixel write per accepted valid/ready transfer.
module rect_fill_writer #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [9:0]  rect_x,
  input  logic [9:0]  rect_y,
  input  logic [9:0]  rect_w,
  input  logic [9:0]  rect_h,
  input  logic [15:0] color,
  output logic        busy,
  output logic        done,
  output logic [9:0]  program_x,
  output logic [9:0]  program_y,
  output logic [15:0] program_data,
  output logic        program_valid,
  input  logic        program_ready
);

  localparam logic [10:0] W_LIM = 11'(SCREEN_W);
  localparam logic [10:0] H_LIM = 11'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_rect_x, r_rect_y, r_rect_w, r_rect_h;
  logic [15:0] r_color;
  logic [10:0] r_x_end, r_y_end;
  logic [9:0]  r_cur_x, r_cur_y;

  logic [10:0] w_sum_x, w_sum_y, w_x_end, w_y_end, w_nx, w_ny;
  logic        w_empty, w_accept, w_row_end, w_last;

  // 11-bit sums so that e.g. 1000+100 clamps instead of wrapping
  assign w_sum_x   = {1'b0, r_rect_x} + {1'b0, r_rect_w};
  assign w_sum_y   = {1'b0, r_rect_y} + {1'b0, r_rect_h};
  assign w_x_end   = (w_sum_x > W_LIM) ? W_LIM : w_sum_x;
  assign w_y_end   = (w_sum_y > H_LIM) ? H_LIM : w_sum_y;
  assign w_empty   = (r_rect_w == 10'd0) || (r_rect_h == 10'd0) ||
                     ({1'b0, r_rect_x} >= W_LIM) || ({1'b0, r_rect_y} >= H_LIM);
  assign w_accept  = (r_state == S_RUN) && program_ready;
  assign w_nx      = {1'b0, r_cur_x} + 11'd1;
  assign w_ny      = {1'b0, r_cur_y} + 11'd1;
  assign w_row_end = (w_nx >= r_x_end);
  assign w_last    = w_row_end && (w_ny >= r_y_end);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLIP;
      S_CLIP:  w_next = w_empty ? S_DONE : S_RUN;
      S_RUN:   if (w_accept && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rect_x <= '0;
      r_rect_y <= '0;
      r_rect_w <= '0;
      r_rect_h <= '0;
      r_color  <= '0;
      r_x_end  <= '0;
      r_y_end  <= '0;
      r_cur_x  <= '0;
      r_cur_y  <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_rect_x <= rect_x;
        r_rect_y <= rect_y;
        r_rect_w <= rect_w;
        r_rect_h <= rect_h;
        r_color  <= color;
      end
      if (r_state == S_CLIP) begin
        r_x_end <= w_x_end;
        r_y_end <= w_y_end;
        if (!w_empty) begin
          r_cur_x <= r_rect_x;
          r_cur_y <= r_rect_y;
        end
      end
      // Position only advances on an accepted transfer, so stalls hold the port stable
      if (w_accept) begin
        if (!w_row_end) begin
          r_cur_x <= w_nx[9:0];
        end else begin
          r_cur_x <= r_rect_x;
          r_cur_y <= w_ny[9:0];
        end
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign program_valid = (r_state == S_RUN);
  assign program_x     = r_cur_x;
  assign program_y     = r_cur_y;
  assign program_data  = r_color;

endmodule

// File: tb/tb_rect_fill_writer.sv
// tb/tb_rect_fill_writer.sv - directed self-checking bench for rect_fill_writer
module tb_rect_fill_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  rect_x = '0, rect_y = '0, rect_w = '0, rect_h = '0;
  logic [15:0] color = '0;
  logic        busy, done, program_valid;
  logic        program_ready = 1'b0;
  logic [9:0]  program_x, program_y;
  logic [15:0] program_data;

  int total = 0;
  int bad = 0;

  logic [9:0]  acc_x[$];
  logic [9:0]  acc_y[$];
  logic [15:0] acc_d[$];
  int          acc_c[$];
  int done_cyc, done_cnt, busy_first, busy_last, valid_cnt, hold_err, range_err;

  rect_fill_writer #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .color(color), .busy(busy), .done(done),
    .program_x(program_x), .program_y(program_y), .program_data(program_data),
    .program_valid(program_valid), .program_ready(program_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always 1; mode 1: ready 0,1,0,0,1 repeating from cycle 2
  function automatic logic ready_for(input int mode, input int cyc);
    int idx;
    if (mode == 0 || cyc < 2) return 1'b1;
    idx = (cyc - 2) % 5;
    return (idx == 1 || idx == 4);
  endfunction

  // Drives one command and records what the port did, cycle 0 = start cycle
  task automatic run_cmd(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                         input logic [9:0] h, input logic [15:0] c, input int rmode,
                         input int inj_cyc, input int max_cyc);
    logic pv, pr;
    logic [9:0] px, py;
    logic [15:0] pd;
    acc_x.delete(); acc_y.delete(); acc_d.delete(); acc_c.delete();
    done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1;
    valid_cnt = 0; hold_err = 0; range_err = 0;
    pv = 1'b0; pr = 1'b0; px = '0; py = '0; pd = '0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      start = (cyc == 0) || (cyc == inj_cyc);
      if (cyc == 0) begin
        rect_x = x; rect_y = y; rect_w = w; rect_h = h; color = c;
      end else if (cyc == inj_cyc) begin
        rect_x = 10'd0; rect_y = 10'd0; rect_w = 10'd5; rect_h = 10'd5; color = 16'h1234;
      end
      program_ready = ready_for(rmode, cyc);
      if (busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (program_valid) begin
        valid_cnt++;
        if (program_x >= 10'd640 || program_y >= 10'd480) range_err++;
      end
      if (pv && !pr && (!program_valid || program_x !== px || program_y !== py || program_data !== pd))
        hold_err++;
      if (program_valid && program_ready) begin
        acc_x.push_back(program_x); acc_y.push_back(program_y);
        acc_d.push_back(program_data); acc_c.push_back(cyc);
      end
      pv = program_valid; pr = program_ready; px = program_x; py = program_y; pd = program_data;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      tick();
    end
    start = 1'b0;
    program_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    total++;
    if ({busy, done, program_valid} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000", {busy, done, program_valid});
    end
    total++;
    if ({program_x, program_y, program_data} !== 36'd0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {program_x, program_y, program_data});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int ex[4] = '{10, 11, 10, 11};
    int ey[4] = '{20, 20, 21, 21};
    run_cmd(10'd10, 10'd20, 10'd2, 10'd2, 16'hF800, 0, -1, 40);
    total++;
    if (acc_x.size() != 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", acc_x.size()); end
    for (int i = 0; i < 4 && i < acc_x.size(); i++) begin
      total++;
      if (acc_x[i] !== 10'(ex[i]) || acc_y[i] !== 10'(ey[i]) || acc_d[i] !== 16'hF800 || acc_c[i] != i + 2) begin
        bad++;
        $display("FAIL basic_pix%0d got=(%0d,%0d,%h,c%0d) exp=(%0d,%0d,f800,c%0d)",
                 i, acc_x[i], acc_y[i], acc_d[i], acc_c[i], ex[i], ey[i], i + 2);
      end
    end
    total++;
    if (done_cyc != 6 || done_cnt != 1) begin
      bad++; $display("FAIL basic_done got=c%0d n%0d exp=c6 n1", done_cyc, done_cnt);
    end
    total++;
    if (busy_first != 1 || busy_last != 6 || valid_cnt != 4) begin
      bad++; $display("FAIL basic_busy got=%0d..%0d v%0d exp=1..6 v4", busy_first, busy_last, valid_cnt);
    end
  endtask

  task automatic test_backpressure();
    int ex[4] = '{10, 11, 10, 11};
    int ey[4] = '{20, 20, 21, 21};
    int ec[4] = '{3, 6, 8, 11};
    run_cmd(10'd10, 10'd20, 10'd2, 10'd2, 16'hF800, 1, -1, 60);
    total++;
    if (acc_x.size() != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", acc_x.size()); end
    for (int i = 0; i < 4 && i < acc_x.size(); i++) begin
      total++;
      if (acc_x[i] !== 10'(ex[i]) || acc_y[i] !== 10'(ey[i]) || acc_c[i] != ec[i]) begin
        bad++;
        $display("FAIL bp_pix%0d got=(%0d,%0d,c%0d) exp=(%0d,%0d,c%0d)",
                 i, acc_x[i], acc_y[i], acc_c[i], ex[i], ey[i], ec[i]);
      end
    end
    total++;
    if (hold_err != 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
    total++;
    if (done_cyc != 12 || done_cnt != 1) begin
      bad++; $display("FAIL bp_done got=c%0d n%0d exp=c12 n1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_clipping();
    int ex[4] = '{638, 639, 638, 639};
    int ey[4] = '{478, 478, 479, 479};
    run_cmd(10'd638, 10'd478, 10'd5, 10'd5, 16'h07E0, 0, -1, 40);
    total++;
    if (acc_x.size() != 4) begin bad++; $display("FAIL clip_count got=%0d exp=4", acc_x.size()); end
    for (int i = 0; i < 4 && i < acc_x.size(); i++) begin
      total++;
      if (acc_x[i] !== 10'(ex[i]) || acc_y[i] !== 10'(ey[i]) || acc_d[i] !== 16'h07E0) begin
        bad++;
        $display("FAIL clip_pix%0d got=(%0d,%0d,%h) exp=(%0d,%0d,07e0)",
                 i, acc_x[i], acc_y[i], acc_d[i], ex[i], ey[i]);
      end
    end
    total++;
    if (range_err != 0 || valid_cnt != 4) begin
      bad++; $display("FAIL clip_range got=r%0d v%0d exp=r0 v4", range_err, valid_cnt);
    end
    total++;
    if (done_cyc != 6) begin bad++; $display("FAIL clip_done got=%0d exp=6", done_cyc); end
  endtask

  task automatic test_degenerate();
    run_cmd(10'd5, 10'd5, 10'd0, 10'd3, 16'hFFFF, 0, -1, 20);
    total++;
    if (done_cyc != 2 || done_cnt != 1 || valid_cnt != 0 || busy_first != 1 || busy_last != 2) begin
      bad++;
      $display("FAIL degen_w0 got=d%0d n%0d v%0d b%0d..%0d exp=d2 n1 v0 b1..2",
               done_cyc, done_cnt, valid_cnt, busy_first, busy_last);
    end
    run_cmd(10'd700, 10'd5, 10'd3, 10'd3, 16'hFFFF, 0, -1, 20);
    total++;
    if (done_cyc != 2 || done_cnt != 1 || valid_cnt != 0 || busy_first != 1 || busy_last != 2) begin
      bad++;
      $display("FAIL degen_x700 got=d%0d n%0d v%0d b%0d..%0d exp=d2 n1 v0 b1..2",
               done_cyc, done_cnt, valid_cnt, busy_first, busy_last);
    end
  endtask

  task automatic test_start_ignored();
    int ex[3] = '{40, 41, 42};
    run_cmd(10'd40, 10'd50, 10'd3, 10'd1, 16'h001F, 0, 3, 40);
    total++;
    if (acc_x.size() != 3 || done_cnt != 1 || done_cyc != 5) begin
      bad++; $display("FAIL ign_run got=n%0d d%0d c%0d exp=n3 d1 c5", acc_x.size(), done_cnt, done_cyc);
    end
    for (int i = 0; i < 3 && i < acc_x.size(); i++) begin
      total++;
      if (acc_x[i] !== 10'(ex[i]) || acc_y[i] !== 10'd50 || acc_d[i] !== 16'h001F) begin
        bad++;
        $display("FAIL ign_pix%0d got=(%0d,%0d,%h) exp=(%0d,50,001f)", i, acc_x[i], acc_y[i], acc_d[i], ex[i]);
      end
    end
    // start held during the DONE cycle must not launch a new command
    run_cmd(10'd40, 10'd50, 10'd3, 10'd1, 16'h001F, 0, 5, 40);
    total++;
    if (acc_x.size() != 3 || done_cnt != 1 || busy_last != 5) begin
      bad++; $display("FAIL ign_done got=n%0d d%0d b%0d exp=n3 d1 b5", acc_x.size(), done_cnt, busy_last);
    end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    int viol = 0;
    start = 1'b1; rect_x = 10'd100; rect_y = 10'd200; rect_w = 10'd4; rect_h = 10'd4;
    color = 16'hABCD; program_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && cnt < 5; i++) begin
      if (program_valid && program_ready) cnt++;
      tick();
    end
    total++;
    if (cnt != 5) begin bad++; $display("FAIL rst_pre got=%0d exp=5", cnt); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++;
    if ({busy, done, program_valid} !== 3'b000 || {program_x, program_y, program_data} !== 36'd0) begin
      bad++;
      $display("FAIL rst_mid got=b%b d%b v%b x%0d y%0d %h exp=all0",
               busy, done, program_valid, program_x, program_y, program_data);
    end
    for (int i = 0; i < 4; i++) begin
      if (done || program_valid || busy) viol++;
      tick();
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL rst_quiet got=%0d exp=0", viol); end
    run_cmd(10'd5, 10'd6, 10'd1, 10'd1, 16'h5A5A, 0, -1, 20);
    total++;
    if (acc_x.size() != 1 || done_cyc != 3 || done_cnt != 1) begin
      bad++; $display("FAIL rst_fresh got=n%0d d%0d exp=n1 d3", acc_x.size(), done_cyc);
    end else begin
      total++;
      if (acc_x[0] !== 10'd5 || acc_y[0] !== 10'd6 || acc_d[0] !== 16'h5A5A || acc_c[0] != 2) begin
        bad++;
        $display("FAIL rst_fresh_pix got=(%0d,%0d,%h,c%0d) exp=(5,6,5a5a,c2)", acc_x[0], acc_y[0], acc_d[0], acc_c[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clipping();
    test_degenerate();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
